// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimator: counter sizing and integrator bit growth.
package cic_pkg;

  // Width of a counter that spans 0..r-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(int unsigned r);
    return (r < 2) ? 1 : $clog2(r);
  endfunction

  // CIC gain growth in bits; integrators size m as input width plus this.
  function automatic int unsigned gain_bits(int unsigned s, int unsigned r);
    return s * $clog2(r);
  endfunction

endpackage

// File: rtl/comb_stage.sv
// One first-order differentiator: y = x - d, with d loaded from x when en is high.
module comb_stage #(
  parameter int unsigned m = 17
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [m-1:0] x,
  output logic [m-1:0] y
);

  logic [m-1:0] d_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      d_q <= '0;
    end else if (en) begin
      d_q <= x;
    end
  end

  assign y = x - d_q;

endmodule

// File: rtl/cic_comb.sv
// Decimating comb section of a CIC decimator: samples in every r clocks, s comb stages.
// Define CIC_COMB_ROUND_EN to round half up instead of truncating the dropped LSBs.
module cic_comb
  import cic_pkg::*;
#(
  parameter int unsigned m = 17,
  parameter int unsigned o = 16,
  parameter int unsigned r = 8,
  parameter int unsigned s = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [m-1:0] in,
  output logic [o-1:0] out,
  output logic         stb
);

  localparam int unsigned cw = cnt_width(r);
  localparam logic [cw-1:0] cnt_max = cw'(r - 1);

  logic [cw-1:0] cnt_q;
  logic          tick;
  logic [m-1:0]  x [s+1];
  logic [m-1:0]  xs_adj;
  logic [o-1:0]  out_q;
  logic          stb_q;

  assign tick = (cnt_q == cnt_max);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + cw'(1);
    end
  end

  assign x[0] = in;

  for (genvar k = 0; k < s; k++) begin : g_stage
    comb_stage #(
      .m(m)
    ) u_stage (
      .clk(clk),
      .clr(clr),
      .en (tick),
      .x  (x[k]),
      .y  (x[k+1])
    );
  end

`ifdef CIC_COMB_ROUND_EN
  if (m > o) begin : g_round
    // Half an output LSB; the sum wraps in m bits like the rest of the datapath.
    localparam logic [m-1:0] round_inc = m'(1) << (m - o - 1);
    assign xs_adj = x[s] + round_inc;
  end else begin : g_no_round
    assign xs_adj = x[s];
  end
`else
  assign xs_adj = x[s];
`endif

  if (m > o) begin : g_drop_lsb
    logic unused_lsb;
    assign unused_lsb = ^xs_adj[m-o-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out_q <= '0;
      stb_q <= 1'b0;
    end else begin
      stb_q <= tick;
      if (tick) begin
        out_q <= xs_adj[m-1 -: o];
      end
    end
  end

  assign out = out_q;
  assign stb = stb_q;

endmodule

// File: tb/tb_cic_comb.sv
// Self-checking bench for cic_comb: three configurations against a binomial-difference model.
module tb_cic_comb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_a, clr_b, clr_c;
  logic [16:0] in_a, out_a, in_b;
  logic [15:0] out_b;
  logic [7:0]  in_c, out_c;
  logic        stb_a, stb_b, stb_c;

  cic_comb #(.m(17), .o(17), .r(4), .s(1)) u_a (
    .clk(clk), .clr(clr_a), .in(in_a), .out(out_a), .stb(stb_a)
  );
  cic_comb #(.m(17), .o(16), .r(2), .s(2)) u_b (
    .clk(clk), .clr(clr_b), .in(in_b), .out(out_b), .stb(stb_b)
  );
  cic_comb #(.m(8), .o(8), .r(2), .s(1)) u_c (
    .clk(clk), .clr(clr_c), .in(in_c), .out(out_c), .stb(stb_c)
  );

  int checks = 0;
  int errors = 0;

  int mp [3] = '{17, 17, 8};
  int op [3] = '{17, 16, 8};
  int rp [3] = '{4, 2, 2};
  int sp [3] = '{1, 2, 1};

  longint     hist [3][$];
  int         kcnt [3];
  logic [63:0] eo [3];
  logic        es [3];
  longint     cur_in [3];
  logic       cur_clr [3];

  logic [63:0] obs_out [3];
  logic        obs_stb [3];

  always_comb begin
    obs_out[0] = 64'(out_a);
    obs_out[1] = 64'(out_b);
    obs_out[2] = 64'(out_c);
    obs_stb[0] = stb_a;
    obs_stb[1] = stb_b;
    obs_stb[2] = stb_c;
  end

  // Keep the top o bits of xs mod 2^m, optionally rounding half up first.
  function automatic logic [63:0] reduce(longint xs, int m, int o);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (64'd1 << m) - 64'd1;
    v = 64'(xs) & mask;
`ifdef CIC_COMB_ROUND_EN
    if (m > o) v = (v + (64'd1 << (m - o - 1))) & mask;
`endif
    return v >> (m - o);
  endfunction

  // s-th difference of the decimated samples: sum_j (-1)^j C(s,j) h[n-j].
  function automatic logic [63:0] comb_ref(int id);
    longint acc = 0;
    longint c = 1;
    longint h;
    for (int j = 0; j <= sp[id]; j++) begin
      h = (j < hist[id].size()) ? hist[id][j] : 0;
      acc += ((j % 2) != 0) ? -c * h : c * h;
      c = c * (sp[id] - j) / (j + 1);
    end
    return reduce(acc, mp[id], op[id]);
  endfunction

  // Drive one instance's inputs, advance one clock, update every instance's model.
  task automatic step(input int id, input longint v, input logic c);
    cur_in[id]  = v;
    cur_clr[id] = c;
    in_a = 17'(cur_in[0]); clr_a = cur_clr[0];
    in_b = 17'(cur_in[1]); clr_b = cur_clr[1];
    in_c = 8'(cur_in[2]);  clr_c = cur_clr[2];
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (cur_clr[i]) begin
        kcnt[i] = 0;
        hist[i].delete();
        eo[i] = '0;
        es[i] = 1'b0;
      end else begin
        kcnt[i]++;
        if (kcnt[i] % rp[i] == 0) begin
          hist[i].push_front(cur_in[i]);
          if (hist[i].size() > 5) void'(hist[i].pop_back());
          es[i] = 1'b1;
          eo[i] = comb_ref(i);
        end else begin
          es[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 100, 1'b1);
      checks++;
      if (stb_a !== 1'b0) begin
        errors++; $display("FAIL reset_stb: got %0b, want 0", stb_a);
      end
      checks++;
      if (out_a !== 17'd0) begin
        errors++; $display("FAIL reset_out: got %0d, want 0", out_a);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      step(0, 100, 1'b0);
      checks++;
      if (stb_a !== (i == 4)) begin
        errors++; $display("FAIL first_stb cycle %0d: got %0b, want %0b", i, stb_a, (i == 4));
      end
    end
    checks++;
    if (out_a !== 17'd100) begin
      errors++; $display("FAIL first_out: got %0d, want 100", out_a);
    end
  endtask

  task automatic test_constant_rate();
    longint acc = 0;
    int last = -1;
    int nstb = 0;
    step(0, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      acc += 5;
      step(0, acc, 1'b0);
      checks++;
      if (obs_stb[0] !== es[0] || obs_out[0] !== eo[0]) begin
        errors++;
        $display("FAIL const_model cycle %0d: got stb=%0b out=%0d, want stb=%0b out=%0d",
                 i, obs_stb[0], obs_out[0], es[0], eo[0]);
      end
      if (stb_a === 1'b1) begin
        if (nstb >= 1) begin
          checks++;
          if (out_a !== 17'd20) begin
            errors++; $display("FAIL const_out: got %0d, want 20", out_a);
          end
          checks++;
          if (i - last != 4) begin
            errors++; $display("FAIL const_period: got %0d, want 4", i - last);
          end
        end
        last = i;
        nstb++;
      end
    end
    checks++;
    if (nstb != 10) begin
      errors++; $display("FAIL const_strobe_count: got %0d, want 10", nstb);
    end
  endtask

  task automatic test_wraparound();
    step(2, 0, 1'b1);
    step(2, 120, 1'b0);
    step(2, 120, 1'b0);
    checks++;
    if (stb_c !== 1'b1 || out_c !== 8'd120) begin
      errors++; $display("FAIL wrap_first: got stb=%0b out=%0d, want stb=1 out=120", stb_c, out_c);
    end
    step(2, -116, 1'b0);
    step(2, -116, 1'b0);
    checks++;
    if (stb_c !== 1'b1 || out_c !== 8'd20) begin
      errors++; $display("FAIL wrap_second: got stb=%0b out=%0d, want stb=1 out=20", stb_c, out_c);
    end
  endtask

  task automatic test_two_stage_step();
    longint samples [5] = '{0, 10, 30, 60, 100};
    step(1, 0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      step(1, samples[j], 1'b0);
      checks++;
      if (stb_b !== 1'b0) begin
        errors++; $display("FAIL step_stb_low %0d: got %0b, want 0", j, stb_b);
      end
      step(1, samples[j], 1'b0);
      checks++;
      // Second difference is 0 then 10; dropping one LSB of 10 gives 5 either way.
      if (stb_b !== 1'b1 || out_b !== ((j == 0) ? 16'd0 : 16'd5)) begin
        errors++;
        $display("FAIL step_out %0d: got stb=%0b out=%0d, want stb=1 out=%0d",
                 j, stb_b, out_b, (j == 0) ? 0 : 5);
      end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] want_pos, want_neg;
`ifdef CIC_COMB_ROUND_EN
    want_pos = 16'd2;
    want_neg = 16'hFFFF;
`else
    want_pos = 16'd1;
    want_neg = 16'hFFFE;
`endif
    step(1, 0, 1'b1);
    step(1, 3, 1'b0);
    step(1, 3, 1'b0);
    checks++;
    if (out_b !== want_pos) begin
      errors++; $display("FAIL round_pos: got %0h, want %0h", out_b, want_pos);
    end
    step(1, 0, 1'b1);
    step(1, -3, 1'b0);
    step(1, -3, 1'b0);
    checks++;
    if (out_b !== want_neg) begin
      errors++; $display("FAIL round_neg: got %0h, want %0h", out_b, want_neg);
    end
  endtask

  task automatic test_clear_vs_tick();
    step(0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 55, 1'b0);
    step(0, 55, 1'b1);
    checks++;
    if (stb_a !== 1'b0 || out_a !== 17'd0) begin
      errors++; $display("FAIL clr_tick: got stb=%0b out=%0d, want stb=0 out=0", stb_a, out_a);
    end
    for (int i = 1; i <= 4; i++) begin
      step(0, 77, 1'b0);
      checks++;
      if (stb_a !== (i == 4)) begin
        errors++; $display("FAIL clr_restart cycle %0d: got %0b, want %0b", i, stb_a, (i == 4));
      end
    end
    checks++;
    if (out_a !== 17'd77) begin
      errors++; $display("FAIL clr_restart_out: got %0d, want 77", out_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      cur_in[0]  = longint'($urandom);
      cur_in[1]  = longint'($urandom);
      cur_clr[0] = ($urandom_range(0, 39) == 0);
      cur_clr[1] = ($urandom_range(0, 39) == 0);
      step(2, longint'($urandom), $urandom_range(0, 39) == 0);
      for (int id = 0; id < 3; id++) begin
        checks++;
        if (obs_stb[id] !== es[id] || obs_out[id] !== eo[id]) begin
          errors++;
          $display("FAIL random id=%0d cycle %0d: got stb=%0b out=%0h, want stb=%0b out=%0h",
                   id, n, obs_stb[id], obs_out[id], es[id], eo[id]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cur_in[i]  = 0;
      cur_clr[i] = 1'b1;
      kcnt[i]    = 0;
      eo[i]      = '0;
      es[i]      = 1'b0;
    end
    clr_a = 1'b1; clr_b = 1'b1; clr_c = 1'b1;
    in_a = '0; in_b = '0; in_c = '0;
    @(negedge clk);
    test_reset();
    test_constant_rate();
    test_wraparound();
    test_two_stage_step();
    test_rounding();
    test_clear_vs_tick();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
